// File: rtl/spi_master.sv
`timescale 1ns/1ps
// SPI initiator: one DATA_WIDTH word per transaction, full duplex, CPOL/CPHA selectable.
// Latency: cs_n low (2*DATA_WIDTH+2)*CLK_DIV cycles; rx_valid on cs_n release; CLK_DIV-cycle gap before the next accept.
// Backpressure: tx_ready only in IDLE; tx_valid at any other time is dropped, never queued.
//
// Ports:
//   clk, rst_n         system clock, async active-low reset
//   tx_data/valid/ready request word (MSB first) with valid/ready handshake
//   rx_data/rx_valid   received word, held until the next one-cycle rx_valid pulse
//   busy               high whenever not IDLE
//   cpol, cpha         bus mode, latched at accept
//   sclk, mosi, cs_n   bus outputs (registered); miso bus input (no synchroniser)
module spi_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  input  logic                  cpol,
  input  logic                  cpha,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs_n
);

  localparam int HW = $clog2(CLK_DIV);
  localparam int EW = $clog2(2*DATA_WIDTH+1);
  localparam logic [HW-1:0] HC_LAST   = HW'(CLK_DIV-1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(2*DATA_WIDTH-1);

  typedef enum logic [2:0] {IDLE, SETUP, TRANSFER, HOLD, GAP} state_t;

  state_t                state;
  logic [HW-1:0]         hcnt;      // clk cycles within the current half-period/phase
  logic [EW-1:0]         ecnt;      // sclk edges generated so far
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic                  cpol_q;
  logic                  cpha_q;

  logic hc_wrap;
  logic sample_edge;

  assign hc_wrap = (hcnt == HC_LAST);
  // The edge about to be produced is a leading (odd) edge when ecnt is even.
  // Mode 0/2 samples on leading edges, mode 1/3 on trailing edges.
  assign sample_edge = ~ecnt[0] ^ cpha_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hcnt     <= '0;
      ecnt     <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= 1'b1;
      tx_ready <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          sclk <= cpol;
          mosi <= 1'b0;
          cs_n <= 1'b1;
          busy <= 1'b0;
          if (tx_valid && tx_ready) begin
            // Mode 0/2 presents the MSB immediately, so the shifter starts
            // one bit ahead; mode 1/3 drives the MSB on the first edge.
            tx_shift <= cpha ? tx_data : (tx_data << 1);
            mosi     <= cpha ? 1'b0 : tx_data[DATA_WIDTH-1];
            cpol_q   <= cpol;
            cpha_q   <= cpha;
            rx_shift <= '0;
            hcnt     <= '0;
            ecnt     <= '0;
            cs_n     <= 1'b0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= SETUP;
          end else begin
            tx_ready <= 1'b1;
          end
        end

        SETUP: begin
          sclk <= cpol_q;
          if (hc_wrap) begin
            hcnt  <= '0;
            state <= TRANSFER;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end

        TRANSFER: begin
          if (hc_wrap) begin
            hcnt <= '0;
            sclk <= ~sclk;
            ecnt <= ecnt + 1'b1;
            if (sample_edge) begin
              rx_shift <= {rx_shift[DATA_WIDTH-2:0], miso};
            end else if (ecnt != EDGE_LAST) begin
              // Final edge of mode 0/2 is a shift edge but there is no bit left.
              mosi     <= tx_shift[DATA_WIDTH-1];
              tx_shift <= tx_shift << 1;
            end
            // An even edge count always leaves sclk back at cpol.
            if (ecnt == EDGE_LAST) state <= HOLD;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end

        HOLD: begin
          sclk <= cpol_q;
          if (hc_wrap) begin
            hcnt     <= '0;
            cs_n     <= 1'b1;
            mosi     <= 1'b0;
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
            state    <= GAP;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end

        GAP: begin
          if (hc_wrap) begin
            hcnt     <= '0;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
`timescale 1ns/1ps
// Bench for spi_master: directed scenarios plus randomized words/modes,
// checked against an SPI peripheral model that reacts to observed sclk/cs_n
// activity and independently tracks edge counts, cs_n timing and mosi edge rules.
module tb_spi_master;

  localparam int DW = 8;
  localparam int CD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          busy;
  logic          cpol;
  logic          cpha;
  logic          sclk;
  logic          mosi;
  logic          miso = 1'b0;
  logic          cs_n;

  spi_master #(.DATA_WIDTH(DW), .CLK_DIV(CD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .cpol     (cpol),
    .cpha     (cpha),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso),
    .cs_n     (cs_n)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- peripheral model / bus monitor ----------------
  logic [DW-1:0] nxt_slave = '0;   // word the peripheral returns next
  logic          nxt_cpol  = 1'b0;
  logic          nxt_cpha  = 1'b0;
  logic [DW-1:0] s_tx = '0;
  logic [DW-1:0] s_rx = '0;
  int            s_left = 0;        // bits still to put on miso
  logic          m_cpol = 1'b0;
  logic          m_cpha = 1'b0;
  logic          prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;
  logic          lead;
  int mon_edges = 0, cs_low = 0, cs_high = 0, cs_fall_cnt = 0, rxv_cnt = 0;
  int last_edges = 0, last_cs_low = 0, last_gap = 0, mon_bad = 0, bad_ready = 0;
  logic [DW-1:0] last_slave_rx = '0;

  always @(negedge clk) begin
    if (prev_cs && !cs_n) begin
      cs_fall_cnt++;
      last_gap  = cs_high;
      m_cpol    = nxt_cpol;
      m_cpha    = nxt_cpha;
      s_rx      = '0;
      mon_edges = 0;
      cs_low    = 0;
      s_tx      = nxt_slave;
      s_left    = DW;
      if (sclk !== m_cpol) mon_bad++;
      if (m_cpha) begin
        if (mosi !== 1'b0) mon_bad++;
      end else begin
        miso = s_tx[DW-1];
        s_tx = s_tx << 1;
        s_left--;
      end
    end
    if (!cs_n) begin
      cs_low++;
      if (!prev_cs && sclk !== prev_sclk) begin
        mon_edges++;
        lead = (sclk !== m_cpol);
        if (lead ^ m_cpha) begin
          s_rx = {s_rx[DW-2:0], mosi};
        end else if (s_left > 0) begin
          miso = s_tx[DW-1];
          s_tx = s_tx << 1;
          s_left--;
        end
      end
      if (!prev_cs && mosi !== prev_mosi) begin
        // mosi may only move together with a shift edge, never on a sample edge
        if (sclk === prev_sclk) mon_bad++;
        else if ((sclk !== m_cpol) ^ m_cpha) mon_bad++;
      end
    end else begin
      if (!prev_cs) begin
        last_edges    = mon_edges;
        last_cs_low   = cs_low;
        last_slave_rx = s_rx;
        cs_high       = 0;
      end
      cs_high++;
    end
    if (rx_valid) rxv_cnt++;
    if (tx_ready && (busy || !cs_n)) bad_ready++;
    prev_cs   = cs_n;
    prev_sclk = sclk;
    prev_mosi = mosi;
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_ready();
    int n = 0;
    while (tx_ready !== 1'b1 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_tx_ready", 32'(tx_ready), 32'd1);
  endtask

  task automatic start_xfer(input logic [DW-1:0] tx, input logic [DW-1:0] sw,
                            input logic pol, input logic pha);
    cpol = pol; cpha = pha; tx_data = tx;
    nxt_cpol = pol; nxt_cpha = pha; nxt_slave = sw;
    wait_ready();
    @(posedge clk); #1;
    chk("sclk_idle_before", 32'(sclk), 32'(pol));
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic finish_xfer(input logic [DW-1:0] exp_rx, input logic [DW-1:0] exp_slave,
                             input logic pol);
    int n = 0;
    while (rx_valid !== 1'b1 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rx_valid_seen", 32'(rx_valid), 32'd1);
    chk("cs_n_at_rx_valid", 32'(cs_n), 32'd1);
    chk("rx_data", 32'(rx_data), 32'(exp_rx));
    @(negedge clk); #1;
    chk("slave_rx", 32'(last_slave_rx), 32'(exp_slave));
    chk("sclk_edges", last_edges, 2*DW);
    chk("cs_low_cycles", last_cs_low, (2*DW+2)*CD);
    chk("sclk_idle_after", 32'(sclk), 32'(pol));
    chk("mosi_edge_rule", mon_bad, 0);
    @(posedge clk); #1;
    chk("rx_valid_single", 32'(rx_valid), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [DW-1:0] w1, w2;
    int rxv0, c0, n, m;

    rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0; cpol = 1'b0; cpha = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Mode 0 and modes 1..3
    rxv0 = rxv_cnt;
    start_xfer(8'hA5, 8'h3C, 1'b0, 1'b0);
    finish_xfer(8'h3C, 8'hA5, 1'b0);
    chk("mode0_one_pulse", rxv_cnt - rxv0, 1);
    for (int md = 1; md < 4; md++) begin
      start_xfer(8'h81, 8'h7E, md[1], md[0]);
      finish_xfer(8'h7E, 8'h81, md[1]);
    end

    // Back-to-back with tx_valid held high
    w1 = 8'h96; w2 = 8'h4B;
    cpol = 1'b0; cpha = 1'b0; nxt_cpol = 1'b0; nxt_cpha = 1'b0; nxt_slave = w1;
    tx_data = 8'h01;
    wait_ready();
    rxv0 = rxv_cnt;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_data = 8'hFF;
    @(negedge clk); #1;
    nxt_slave = w2;
    finish_xfer(w1, 8'h01, 1'b0);
    wait_ready();
    @(posedge clk); #1;
    tx_valid = 1'b0;
    chk("b2b_second_accept", 32'(busy), 32'd1);
    finish_xfer(w2, 8'hFF, 1'b0);
    chk("b2b_gap_min", 32'(last_gap >= CD+1), 32'd1);
    chk("b2b_rx_pulses", rxv_cnt - rxv0, 2);

    // Request mid-transfer is dropped
    c0 = cs_fall_cnt;
    start_xfer(8'hAA, 8'h33, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    tx_data = 8'h55; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    finish_xfer(8'h33, 8'hAA, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    chk("drop_no_extra_cs", cs_fall_cnt - c0, 1);
    chk("drop_idle_busy", 32'(busy), 32'd0);

    // Asynchronous reset at edge 7
    start_xfer(8'h96, 8'h69, 1'b0, 1'b0);
    n = 0;
    while (mon_edges != 7 && n < 1000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("reached_edge7", mon_edges, 7);
    rxv0 = rxv_cnt;
    rst_n = 1'b0;
    #1;
    chk("abort_cs_n", 32'(cs_n), 32'd1);
    chk("abort_sclk", 32'(sclk), 32'd0);
    chk("abort_rx_valid", 32'(rx_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_ready", 32'(tx_ready), 32'd1);
    chk("abort_no_pulse", rxv_cnt - rxv0, 0);
    start_xfer(8'hC3, 8'h5A, 1'b0, 1'b0);
    finish_xfer(8'h5A, 8'hC3, 1'b0);

    // cpol changed mid-transfer takes effect only at the next accept
    start_xfer(8'h3A, 8'hC5, 1'b0, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    cpol = 1'b1;
    finish_xfer(8'hC5, 8'h3A, 1'b0);
    start_xfer(8'h5C, 8'hE1, 1'b1, 1'b0);
    finish_xfer(8'hE1, 8'h5C, 1'b1);

    // Randomized words and modes
    for (int i = 0; i < 8; i++) begin
      w1 = DW'($urandom);
      w2 = DW'($urandom);
      m  = int'($urandom_range(0, 3));
      start_xfer(w1, w2, m[1], m[0]);
      finish_xfer(w2, w1, m[1]);
    end

    chk("tx_ready_only_idle", bad_ready, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI bus initiator: serialises one DATA_WIDTH word per transaction on MOSI and captures the MISO word in parallel, with full-duplex operation on a single chip-select.
- Supports all four CPOL/CPHA modes; SCLK is generated by dividing the system clock.
- Pairs with spi_slave on the same clock domain for loopback subsystems and is the host-side driver for external SPI peripherals.

Parameters:
- DATA_WIDTH, 8, bits per transaction (>=2).
- CLK_DIV, 4, clk cycles per SCLK half-period (>=2; >=4 required when driving spi_slave on the same clk).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- tx_data  in  DATA_WIDTH  word to transmit, MSB first.
- tx_valid  in  1  request; accepted when tx_valid && tx_ready.
- tx_ready  out  1  high only in IDLE.
- rx_data  out  DATA_WIDTH  last received word, held until next rx_valid.
- rx_valid  out  1  one-cycle pulse, rx_data valid.
- busy  out  1  high in every state except IDLE.
- cpol  in  1  clock polarity, sampled at accept.
- cpha  in  1  clock phase, sampled at accept.
- sclk  out  1  serial clock.
- mosi  out  1  serial data out.
- miso  in  1  serial data in, sampled directly without a synchroniser.
- cs_n  out  1  active-low chip select.

Behaviour:
- Reset values: cs_n=1, sclk=0, mosi=0, tx_ready=0 during reset, rx_data=0, rx_valid=0, busy=0, state=IDLE. Asynchronous reset mid-transfer aborts immediately: cs_n=1, no rx_valid pulse.
- IDLE: tx_ready=1; sclk registered from the live cpol each cycle; mosi=0.
  - On accept, latch tx_data into tx_shift, latch cpol/cpha, clear the half-period counter and edge counter, go to SETUP.
  - tx_valid outside IDLE is ignored, not queued.
- SETUP (CLK_DIV cycles): cs_n=0 from the cycle after accept; sclk=cpol.
  - cpha=0: mosi=tx_data MSB from the first SETUP cycle.
  - cpha=1: mosi=0 until the first SCLK edge.
- TRANSFER: the half-period counter runs 0..CLK_DIV-1; on wrap, sclk toggles and the edge counter increments. There are exactly 2*DATA_WIDTH edges; the last edge returns sclk to cpol.
  - Leading edge = odd edge (1st, 3rd, ...); trailing edge = even edge.
  - cpha=0: sample miso into rx_shift (shift left, LSB in) on leading edges; shift mosi to the next bit on trailing edges, except the final one.
  - cpha=1: drive the next mosi bit on leading edges (1st edge drives MSB); sample on trailing edges.
  - Sample and shift take effect in the same clk cycle as the sclk toggle register update.
- HOLD (CLK_DIV cycles): sclk=cpol, mosi holds its last bit, cs_n=0.
  - On exit: cs_n=1, rx_data<=rx_shift, rx_valid=1 for that single cycle; go to GAP.
- GAP (CLK_DIV cycles): cs_n=1, mosi=0, tx_ready=0; then IDLE.
- Timing: cs_n low for exactly (2*DATA_WIDTH+2)*CLK_DIV cycles. Back-to-back transactions start at minimum every (2*DATA_WIDTH+3)*CLK_DIV+1 cycles.
- Counters: half-period counter width clog2(CLK_DIV); edge counter width clog2(2*DATA_WIDTH+1). Neither wraps past its terminal value.
- cpol/cpha changes during a transaction have no effect until the next accept.

Test Plan:
- Mode 0, CLK_DIV=4, tx_data=0xA5, miso driven by spi_slave loaded with 0x3C -> slave receives 0xA5; master rx_data=0x3C with a single rx_valid pulse; cs_n low exactly 72 cycles; 16 sclk edges.
- Modes 1, 2, 3 each with tx_data=0x81 and miso model returning 0x7E -> rx_data=0x7E; sclk idles at cpol before and after; mosi changes only on the specified edges (edge-checker assertion).
- Back-to-back: tx_valid held high with 0x01 then 0xFF -> two transactions; tx_ready low for the full span; cs_n high for >= CLK_DIV+1 cycles between them; rx_valid pulses twice.
- tx_valid pulsed with 0x55 mid-transfer of 0xAA -> only 0xAA sent; 0x55 dropped; no extra cs_n assertion.
- rst_n asserted at edge 7 of a transfer -> cs_n=1, sclk=0, rx_valid=0 immediately; after release, tx_ready=1 and a fresh 0xC3 transfer completes correctly.
- cpol toggled mid-transfer (mode 0 in progress) -> transfer completes in mode 0; the next transfer uses the new cpol.
